decode_execute_reg: RTL and testbench
=====================================

Name: decode_execute_reg

Overview:
Pipeline register between the Decode and Execute stages of the five-stage RV32I core. Captures the decoded control bundle (including the 3-bit ALU control produced in Decode), operands, immediates and register addresses on each clock, and presents them as *E-suffixed signals to the Execute stage. Supports hazard-unit stall and flush (bubble insertion), tracks a per-stage valid bit, and keeps a saturating count of inserted bubbles for performance monitoring.

Parameters:
DATA_WIDTH, 32, width of the operand, PC and immediate fields
REG_ADDR_WIDTH, 5, width of the register-file address fields
BUBBLE_CNT_WIDTH, 16, width of the saturating bubble counter

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
StallE  in  1  hold the current register contents (hazard unit)
FlushE  in  1  load a bubble (hazard unit)
ValidD  in  1  Decode holds a real instruction
RegWriteD  in  1  register-file write enable
ResultSrcD  in  2  writeback source select
MemWriteD  in  1  data-memory write enable
JumpD  in  1  jump instruction
BranchD  in  1  branch instruction
ALUControlD  in  3  ALU operation from the ALU decoder
ALUSrcD  in  1  ALU operand-B select (0 = RD2, 1 = immediate)
funct3D  in  3  branch/load/store sub-op
RD1D, RD2D  in  DATA_WIDTH  register-file read data
PCD, PCPlus4D, ImmExtD  in  DATA_WIDTH  PC, PC+4, extended immediate
Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH  source and destination register addresses
*E outputs  out  same widths  registered copy of every *D input above, including ValidE
BubbleCountE  out  BUBBLE_CNT_WIDTH  number of bubbles inserted since reset (saturating)

Behaviour:
- Reset (rst_n low, asynchronous): every *E output and BubbleCountE go to 0 immediately, regardless of clk. Outputs remain 0 while rst_n is low. The first capture happens on the first rising edge after rst_n goes high.
- Latency: exactly one cycle from a *D input to the matching *E output. There is no combinational path from inputs to outputs.
- Priority on each rising edge: reset > FlushE > StallE > normal load.
- Normal load (FlushE=0, StallE=0): every *E output takes its *D input, and ValidE takes ValidD.
- Stall (StallE=1, FlushE=0): all *E outputs hold their values. BubbleCountE holds.
- Flush (FlushE=1, with any value of StallE): all *E outputs are cleared to 0. This gives RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0, ValidE=0 and ALUControlE=000 (add). This is a NOP bubble.
- Bubble counter: increments by 1 on each edge where FlushE=1. It saturates at all-ones and never wraps.
- ValidD=0 with a normal load: the fields are captured as given and ValidE=0. This does not count as a bubble.
- Mid-operation reset: clears all state, including the counter, and discards any in-flight stall or flush.
- No X-propagation: every output register is reset, including the data fields.

Test Plan:
- Reset: hold rst_n=0 with all inputs non-zero, then toggle clk. Required: all *E=0 and BubbleCountE=0; assert rst_n low between clock edges and check outputs clear without an edge.
- Pass-through: ALUControlD=3'b101, RD1D=0x0000_1234, RdD=5'd7, RegWriteD=1, ValidD=1, one edge. Required: ALUControlE=101, RD1E=0x1234, RdE=7, RegWriteE=1, ValidE=1 one cycle later, with nothing visible before the edge.
- Stall: load ALUControlD=3'b011, then assert StallE for 3 cycles while changing the D inputs. Required: outputs stay 011 and the old values for all 3 cycles, then update on the first edge after StallE drops.
- Flush priority: with the register full, assert FlushE=1 and StallE=1 together for one edge. Required: all *E=0, ValidE=0, MemWriteE=0, BubbleCountE goes from 0 to 1.
- Counter saturation: force 2^16+5 consecutive flushes. Required: BubbleCountE=0xFFFF and stays there with no wrap; a following reset returns it to 0.
- Back-to-back: alternate load/flush/load over 3 edges with distinct PCD values 0x100, 0x104, 0x108. Required: PCE goes 0x100, then 0, then 0x108; BubbleCountE=1.

Source files
------------

// File: rtl/decode_execute_reg.sv
`timescale 1ns/1ps
`default_nettype none
// decode_execute_reg: Decode->Execute pipeline register with stall, flush
// (bubble insertion), per-stage valid bit and a saturating bubble counter.
module decode_execute_reg #(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int BUBBLE_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        StallE,
  input  logic                        FlushE,
  input  logic                        ValidD,
  input  logic                        RegWriteD,
  input  logic [1:0]                  ResultSrcD,
  input  logic                        MemWriteD,
  input  logic                        JumpD,
  input  logic                        BranchD,
  input  logic [2:0]                  ALUControlD,
  input  logic                        ALUSrcD,
  input  logic [2:0]                  funct3D,
  input  logic [DATA_WIDTH-1:0]       RD1D,
  input  logic [DATA_WIDTH-1:0]       RD2D,
  input  logic [DATA_WIDTH-1:0]       PCD,
  input  logic [DATA_WIDTH-1:0]       PCPlus4D,
  input  logic [DATA_WIDTH-1:0]       ImmExtD,
  input  logic [REG_ADDR_WIDTH-1:0]   Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0]   Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0]   RdD,
  output logic                        ValidE,
  output logic                        RegWriteE,
  output logic [1:0]                  ResultSrcE,
  output logic                        MemWriteE,
  output logic                        JumpE,
  output logic                        BranchE,
  output logic [2:0]                  ALUControlE,
  output logic                        ALUSrcE,
  output logic [2:0]                  funct3E,
  output logic [DATA_WIDTH-1:0]       RD1E,
  output logic [DATA_WIDTH-1:0]       RD2E,
  output logic [DATA_WIDTH-1:0]       PCE,
  output logic [DATA_WIDTH-1:0]       PCPlus4E,
  output logic [DATA_WIDTH-1:0]       ImmExtE,
  output logic [REG_ADDR_WIDTH-1:0]   Rs1E,
  output logic [REG_ADDR_WIDTH-1:0]   Rs2E,
  output logic [REG_ADDR_WIDTH-1:0]   RdE,
  output logic [BUBBLE_CNT_WIDTH-1:0] BubbleCountE
);

  localparam int C_BUNDLE_W = 14 + 5 * DATA_WIDTH + 3 * REG_ADDR_WIDTH;
  localparam logic [BUBBLE_CNT_WIDTH-1:0] C_CNT_MAX = {BUBBLE_CNT_WIDTH{1'b1}};

  logic [C_BUNDLE_W-1:0]       bundle_d, bundle_q, w_bundle_in;
  logic [BUBBLE_CNT_WIDTH-1:0] bubble_cnt_d, bubble_cnt_q;

  // The whole control/data bundle moves as one vector, so every field obeys
  // exactly the same flush/stall/load rule.
  assign w_bundle_in = {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
                        ALUControlD, ALUSrcD, funct3D, RD1D, RD2D, PCD, PCPlus4D,
                        ImmExtD, Rs1D, Rs2D, RdD};

  always_comb begin
    bundle_d     = bundle_q;
    bubble_cnt_d = bubble_cnt_q;
    if (FlushE) begin
      bundle_d = '0;
      if (bubble_cnt_q != C_CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + BUBBLE_CNT_WIDTH'(1);
      end
    end else if (!StallE) begin
      bundle_d = w_bundle_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q     <= '0;
      bubble_cnt_q <= '0;
    end else begin
      bundle_q     <= bundle_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
          ALUControlE, ALUSrcE, funct3E, RD1E, RD2E, PCE, PCPlus4E,
          ImmExtE, Rs1E, Rs2E, RdE} = bundle_q;
  assign BubbleCountE = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_reg.sv
`timescale 1ns/1ps
`default_nettype none
// tb_decode_execute_reg: directed stimulus with a queue-based scoreboard and
// an independent per-cycle monitor.
module tb_decode_execute_reg;

  typedef struct packed {
    logic        valid;
    logic        regw;
    logic [1:0]  rsrc;
    logic        memw;
    logic        jump;
    logic        branch;
    logic [2:0]  aluc;
    logic        alusrc;
    logic [2:0]  f3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } in_t;

  typedef struct packed {
    in_t         f;
    logic [15:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic StallE = 1'b0;
  logic FlushE = 1'b0;
  in_t  din;
  obs_t obs, model;
  obs_t sb[$];
  int   total = 0;
  int   bad = 0;

  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE, funct3E;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] BubbleCountE;

  always #5 clk = ~clk;

  decode_execute_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .BUBBLE_CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .ValidD(din.valid), .RegWriteD(din.regw), .ResultSrcD(din.rsrc),
    .MemWriteD(din.memw), .JumpD(din.jump), .BranchD(din.branch),
    .ALUControlD(din.aluc), .ALUSrcD(din.alusrc), .funct3D(din.f3),
    .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc), .PCPlus4D(din.pcp4),
    .ImmExtD(din.imm), .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .funct3E(funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .BubbleCountE(BubbleCountE)
  );

  assign obs = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
                ALUControlE, ALUSrcE, funct3E, RD1E, RD2E, PCE, PCPlus4E,
                ImmExtE, Rs1E, Rs2E, RdE, BubbleCountE};

  task automatic check_obs(input string name, input obs_t act, input obs_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: the register presents a new result after every rising edge.
  always @(posedge clk) begin
    obs_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_obs("pipe", obs, e);
    end
  end

  // Drive one cycle of stimulus and queue the response the register must show after the edge.
  task automatic step(input in_t v, input logic st, input logic fl);
    @(negedge clk);
    din    = v;
    StallE = st;
    FlushE = fl;
    if (fl) begin
      model.f = '0;
      if (model.cnt != 16'hFFFF) model.cnt = model.cnt + 16'd1;
    end else if (!st) begin
      model.f = v;
    end
    sb.push_back(model);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    StallE = 1'b1;
    FlushE = 1'b0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d queued required 0", sb.size());
      sb.delete();
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear with no edge.
  task automatic mid_reset();
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    model = '0;
    check_obs("async_reset", obs, '0);
    @(posedge clk);
    #1;
    check_obs("reset_hold", obs, '0);
    @(negedge clk);
    rst_n  = 1'b1;
    StallE = 1'b0;
  endtask

  initial begin
    in_t v;
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    in_t v;
    din   = '1;
    StallE = 1'b1;
    FlushE = 1'b1;
    model = '0;
    // Reset held with all inputs non-zero across several edges.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_obs("reset_init", obs, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    StallE = 1'b0;
    FlushE = 1'b0;
    din = '0;

    // Pass-through: nothing visible before the edge, exact values after.
    v = '0; v.aluc = 3'b101; v.rd1 = 32'h0000_1234; v.rd = 5'd7; v.regw = 1'b1; v.valid = 1'b1;
    step(v, 1'b0, 1'b0);
    #1;
    check_val("pt_before_edge_alu", {29'd0, ALUControlE}, 32'd0);
    @(posedge clk);
    #2;
    check_val("pt_alu", {29'd0, ALUControlE}, 32'h5);
    check_val("pt_rd1", RD1E, 32'h1234);
    check_val("pt_rd", {27'd0, RdE}, 32'd7);
    check_val("pt_regw_valid", {30'd0, RegWriteE, ValidE}, 32'h3);

    // Stall: load 011, hold 3 cycles while D changes, then update.
    v = '0; v.aluc = 3'b011; v.rd1 = 32'hAAAA_0001; v.pc = 32'h40; v.valid = 1'b1; v.memw = 1'b1;
    step(v, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      v = '0; v.aluc = 3'(i); v.rd1 = 32'hBEEF_0000 + 32'(i); v.pc = 32'h80 + 32'(i * 4); v.rd = 5'd31;
      step(v, 1'b1, 1'b0);
    end
    @(posedge clk);
    #2;
    check_val("stall_alu_held", {29'd0, ALUControlE}, 32'h3);
    check_val("stall_rd1_held", RD1E, 32'hAAAA_0001);
    v = '0; v.aluc = 3'b110; v.rd1 = 32'h5555_0002; v.pc = 32'h44; v.valid = 1'b1; v.memw = 1'b1;
    v.jump = 1'b1; v.rs1 = 5'd3; v.rs2 = 5'd4; v.imm = 32'hFFFF_FFF0; v.f3 = 3'b010; v.rsrc = 2'b10;
    step(v, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check_val("stall_release_alu", {29'd0, ALUControlE}, 32'h6);

    // Flush wins over stall with the register full.
    step(v, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    check_val("flush_valid_memw", {30'd0, ValidE, MemWriteE}, 32'd0);
    check_val("flush_cnt", {16'd0, BubbleCountE}, 32'd1);

    // ValidD=0 load captures fields but is not a bubble.
    v = '0; v.pc = 32'h200; v.rd2 = 32'h0F0F_0F0F; v.branch = 1'b1;
    step(v, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check_val("invalid_load_cnt", {16'd0, BubbleCountE}, 32'd1);
    check_val("invalid_load_pc", PCE, 32'h200);

    // Mid-operation reset discards a pending flush and the counter.
    mid_reset();

    // Back-to-back load/flush/load.
    v = '0; v.valid = 1'b1; v.pc = 32'h100; v.pcp4 = 32'h104;
    step(v, 1'b0, 1'b0);
    @(posedge clk); #2;
    check_val("b2b_pc0", PCE, 32'h100);
    v.pc = 32'h104; v.pcp4 = 32'h108;
    step(v, 1'b0, 1'b1);
    @(posedge clk); #2;
    check_val("b2b_pc1", PCE, 32'h0);
    v.pc = 32'h108; v.pcp4 = 32'h10C;
    step(v, 1'b0, 1'b0);
    @(posedge clk); #2;
    check_val("b2b_pc2", PCE, 32'h108);
    check_val("b2b_cnt", {16'd0, BubbleCountE}, 32'd1);

    // Counter saturation: 2^16+5 consecutive flushes.
    v = '1;
    for (int i = 0; i < 65536 + 5; i++) step(v, 1'b0, 1'b1);
    @(posedge clk); #2;
    check_val("sat_cnt", {16'd0, BubbleCountE}, 32'h0000_FFFF);
    step(v, 1'b1, 1'b1);
    @(posedge clk); #2;
    check_val("sat_no_wrap", {16'd0, BubbleCountE}, 32'h0000_FFFF);
    mid_reset();
    check_val("sat_reset_cnt", {16'd0, BubbleCountE}, 32'd0);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
